// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the SEQ datapath: icodes, status codes and the
// PC/status sequencer state type.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    ERR  = 2'd3
  } pcf_state_t;

  // Highest icode that fetch may legally present.
  function automatic logic icode_legal(input logic [3:0] icode);
    return icode <= IPOPQ;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle between the SEQ datapath (master) and the PC/status
// sequencer (slave).
interface pc_fetch_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [63:0]      pc_new;
  logic [3:0]       icode_f;
  logic             instr_valid;
  logic             imem_error;
  logic             stall;
  logic [63:0]      pc_val;
  logic [2:0]       stat;
  logic             running;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output pc_new, icode_f, instr_valid, imem_error, stall,
    input  pc_val, stat, running, retired_count
  );

  modport slave (
    input  pc_new, icode_f, instr_valid, imem_error, stall,
    output pc_val, stat, running, retired_count
  );
endinterface

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter holding the retired-instruction count; clr_n is an
// asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and Y86 status sequencer for SEQ. Optional macro
// PC_BOUNDS_CHECK_EN turns a next PC at or beyond MEM_BYTES into an ADR fault.
//
// state | meaning
// BOOT  | one cycle after reset, PC not updated
// RUN   | instructions commit on unstalled edges
// HALT  | halt retired, everything frozen until reset
// ERR   | ADR or INS fault, everything frozen until reset
module pc_fetch_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 1024,
  parameter int          CNT_W     = 32
) (
  input  logic clock,
  input  logic reset_n,
  pc_fetch_ctrl_if.slave bus
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  pcf_state_t  state;
  logic [63:0] pc_q;
  logic [2:0]  stat_q;
  logic        running_q;

  logic fault_adr;
  logic fault_ins;
  logic is_halt;
  logic active;
  logic retire;

`ifdef PC_BOUNDS_CHECK_EN
  assign fault_adr = bus.imem_error || (bus.pc_new >= MEM_LIMIT);
`else
  assign fault_adr = bus.imem_error;
`endif
  assign fault_ins = !bus.instr_valid || !icode_legal(bus.icode_f);
  assign is_halt   = (bus.icode_f == IHALT);
  assign active    = (state == RUN) && !bus.stall;
  // Halt retires too, so only the two fault classes suppress the count.
  assign retire    = active && !fault_adr && !fault_ins;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      running_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state     <= RUN;
          running_q <= 1'b1;
        end
        RUN: begin
          if (!bus.stall) begin
            if (fault_adr) begin
              state     <= ERR;
              stat_q    <= STAT_ADR;
              running_q <= 1'b0;
            end else if (fault_ins) begin
              state     <= ERR;
              stat_q    <= STAT_INS;
              running_q <= 1'b0;
            end else if (is_halt) begin
              state     <= HALT;
              stat_q    <= STAT_HLT;
              running_q <= 1'b0;
            end else begin
              pc_q <= bus.pc_new;
            end
          end
        end
        HALT, ERR: begin
          running_q <= 1'b0;
        end
        default: begin
          state     <= ERR;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_retired (
    .clock (clock),
    .clr_n (reset_n),
    .inc   (retire),
    .count (bus.retired_count)
  );

  assign bus.pc_val  = pc_q;
  assign bus.stat    = stat_q;
  assign bus.running = running_q;

endmodule
